gemm_issue_ctrl: RTL

Sequences the GEMM accelerator on behalf of the three-stage pipeline. When the controller's pipelined GEMM flag is high, this block does four things:
- latches the operand registers and the function code;
- issues one command to the GEMM unit over a valid/ready handshake;
- holds the pipeline stalled until the unit reports completion;
- records the operation latency.
It sits between the execute stage, the hazard/stall logic and the GEMM unit.

---
 rtl/gemm_issue_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/gemm_issue_ctrl.sv
// gemm_issue_ctrl: latches GEMM operands, issues one command per instruction, stalls the pipeline until done, records latency; optional watchdog via GEMM_TIMEOUT_EN
module gemm_issue_ctrl #(
  parameter int LAT_W = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gemm_instr,
  input  logic             flush,
  input  logic [2:0]       func3,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_op,
  output logic [31:0]      cmd_addr_a,
  output logic [31:0]      cmd_addr_b,
  input  logic             gemm_done,
  output logic             stall_o,
  output logic             retire_o,
  output logic             busy_o,
  output logic [LAT_W-1:0] last_lat,
  output logic             cmd_abort,
  output logic             err_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_inc;
  logic accept, timeout, finish;
  assign accept = (state == IDLE) & gemm_instr & ~flush;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign finish = (state == WAIT) & (gemm_done | timeout);
`ifdef GEMM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic err;
  assign timeout = (state == WAIT) & ~gemm_done & (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign cmd_abort = timeout & ~rst;
  assign err_o = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
      err <= 1'b0;
    end else begin
      wd <= (state == WAIT) ? wd + 1'b1 : '0;
      err <= err | timeout;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign timeout = 1'b0;
  assign cmd_abort = 1'b0;
  assign err_o = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    stall_o = 1'b0;
    retire_o = 1'b0;
    busy_o = state != IDLE;
    case (state)
      IDLE: begin
        state_nxt = accept ? ISSUE : IDLE;
        stall_o = accept;
      end
      ISSUE: begin
        state_nxt = cmd_ready ? WAIT : ISSUE;
        cmd_valid = 1'b1;
        stall_o = 1'b1;
      end
      WAIT: begin
        state_nxt = finish ? DONE : WAIT;
        stall_o = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        retire_o = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd_op <= '0;
      cmd_addr_a <= '0;
      cmd_addr_b <= '0;
      cnt <= '0;
      last_lat <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_op <= func3;
        cmd_addr_a <= rs1_data;
        cmd_addr_b <= rs2_data;
      end
      cnt <= accept ? LAT_W'(1) : (state == WAIT) ? cnt_inc : cnt;
      if (finish) last_lat <= cnt_inc;
    end
  end
endmodule
